// File: rtl/cgra_cfg_pkg.sv
// Shared types for the CGRA configuration sequencer: the frame layout a PE decodes,
// the source and opcode encodings, and the sequencer FSM state.
package cgra_cfg_pkg;

    localparam int FRAME_WIDTH = 64;

    // Field order is MSB first, so op occupies bits [5:0] and reserved occupies [63:40].
    typedef struct packed {
        logic [23:0] reserved;
        logic [15:0] imm;
        logic        pred_inv;
        logic        pred_en;
        logic [3:0]  route;
        logic [3:0]  dst;
        logic [3:0]  src1;
        logic [3:0]  src0;
        logic [5:0]  op;
    } cfg_frame_t;

    localparam logic [3:0] SRC_N   = 4'd1;
    localparam logic [3:0] SRC_IMM = 4'd6;

    localparam logic [5:0] OP_ADD     = 6'd1;
    localparam logic [5:0] OP_SUB     = 6'd2;
    localparam logic [5:0] OP_MAC     = 6'd4;
    localparam logic [5:0] OP_CMP_GT  = 6'd10;
    localparam logic [5:0] OP_ACC_CLR = 6'd15;
    localparam logic [5:0] OP_LIF     = 6'd18;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } seq_state_e;

    function automatic cfg_frame_t make_frame(input logic [5:0] op, input logic [3:0] src0,
                                              input logic [3:0] src1, input logic [3:0] dst,
                                              input logic [15:0] imm);
        cfg_frame_t f;
        f      = '0;
        f.op   = op;
        f.src0 = src0;
        f.src1 = src1;
        f.dst  = dst;
        f.imm  = imm;
        return f;
    endfunction

endpackage

// File: rtl/cgra_cfg_if.sv
// Host/PE-side signal bundle of the configuration sequencer; master is the host/PE side,
// slave is the sequencer.
interface cgra_cfg_if #(
    parameter int DEPTH      = 16,
    parameter int ITER_WIDTH = 8
);
    localparam int AW = $clog2(DEPTH);

    // config_valid/config_ready: a frame moves in any cycle where both are high. Once
    // config_valid is raised, config_valid and config_frame hold until that transfer
    // (or an abort/reset); config_ready may toggle freely and is never waited on by valid.
    logic                               wr_en;
    logic [AW-1:0]                      wr_addr;
    logic [cgra_cfg_pkg::FRAME_WIDTH-1:0] wr_data;
    logic                               wr_err;
    logic                               start;
    logic [AW:0]                        len;
    logic [ITER_WIDTH-1:0]              loop_count;
    logic                               abort;
    logic [cgra_cfg_pkg::FRAME_WIDTH-1:0] config_frame;
    logic                               config_valid;
    logic                               config_ready;
    logic                               busy;
    logic                               done;
    logic                               aborted;
    logic [ITER_WIDTH-1:0]              iter;
    cgra_cfg_pkg::seq_state_e           dbg_state;

    modport master (
        output wr_en, wr_addr, wr_data, start, len, loop_count, abort, config_ready,
        input  wr_err, config_frame, config_valid, busy, done, aborted, iter, dbg_state
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, len, loop_count, abort, config_ready,
        output wr_err, config_frame, config_valid, busy, done, aborted, iter, dbg_state
    );

endinterface

// File: rtl/cgra_cfg_store.sv
// Frame store: DEPTH x W register array, one synchronous write port and one
// combinational read port. Contents are deliberately not reset.
module cgra_cfg_store #(
    parameter int DEPTH = 16,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cgra_cfg_sequencer.sv
// Plays frames 0..len-1 of the frame store to a PE, loop_count passes, one frame per
// cycle when the PE is ready. The outgoing frame is registered so it holds across stalls.
module cgra_cfg_sequencer
    import cgra_cfg_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int ITER_WIDTH = 8
) (
    input logic        clk,
    input logic        rst,
    cgra_cfg_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    seq_state_e             state_q, state_d;
    logic [AW-1:0]          ptr_q, ptr_d;
    logic [ITER_WIDTH-1:0]  iter_q, iter_d;
    logic [LW-1:0]          len_q, len_d;
    logic [ITER_WIDTH-1:0]  passes_q, passes_d;
    logic [FRAME_WIDTH-1:0] frame_q, frame_d;
    logic                   valid_q, valid_d;
    logic                   done_q, done_d;
    logic                   aborted_q, aborted_d;
    logic                   wr_err_q, wr_err_d;

    logic                   store_we;
    logic [AW-1:0]          rd_addr;
    logic [FRAME_WIDTH-1:0] rd_data;
    logic                   xfer;
    logic                   ptr_last;
    logic                   iter_last;

    cgra_cfg_store #(
        .DEPTH (DEPTH),
        .W     (FRAME_WIDTH)
    ) u_store (
        .clk     (clk),
        .we_i    (store_we),
        .waddr_i (bus.wr_addr),
        .wdata_i (bus.wr_data),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    assign xfer      = valid_q && bus.config_ready;
    assign ptr_last  = ({1'b0, ptr_q} == (len_q - LW'(1)));
    assign iter_last = (iter_q == (passes_q - ITER_WIDTH'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            iter_q    <= '0;
            len_q     <= '0;
            passes_q  <= '0;
            frame_q   <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            wr_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            iter_q    <= iter_d;
            len_q     <= len_d;
            passes_q  <= passes_d;
            frame_q   <= frame_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            wr_err_q  <= wr_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        iter_d    = iter_q;
        len_d     = len_q;
        passes_d  = passes_q;
        frame_d   = frame_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        wr_err_d  = 1'b0;
        store_we  = 1'b0;
        rd_addr   = '0;

        unique case (state_q)
            ST_IDLE: begin
                // A host write in the same cycle as start wins; start is dropped.
                if (bus.wr_en) begin
                    store_we = 1'b1;
                end else if (bus.start) begin
                    if (bus.len == '0) begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = ST_RUN;
                        valid_d  = 1'b1;
                        ptr_d    = '0;
                        iter_d   = '0;
                        len_d    = (bus.len > DEPTH_L) ? DEPTH_L : bus.len;
                        passes_d = (bus.loop_count == '0) ? ITER_WIDTH'(1) : bus.loop_count;
                        rd_addr  = '0;
                        frame_d  = rd_data;
                    end
                end
            end

            ST_RUN: begin
                wr_err_d = bus.wr_en;
                // Abort outranks a coincident transfer: that frame is delivered, nothing follows.
                if (bus.abort) begin
                    state_d   = ST_FIN;
                    valid_d   = 1'b0;
                    aborted_d = 1'b1;
                end else if (xfer) begin
                    if (!ptr_last) begin
                        ptr_d   = ptr_q + AW'(1);
                        rd_addr = ptr_q + AW'(1);
                        frame_d = rd_data;
                    end else if (!iter_last) begin
                        ptr_d   = '0;
                        iter_d  = iter_q + ITER_WIDTH'(1);
                        rd_addr = '0;
                        frame_d = rd_data;
                    end else begin
                        state_d = ST_FIN;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end

            ST_FIN: begin
                wr_err_d = bus.wr_en;
                state_d  = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign bus.config_frame = frame_q;
    assign bus.config_valid = valid_q;
    assign bus.busy         = (state_q == ST_RUN);
    assign bus.done         = done_q;
    assign bus.aborted      = aborted_q;
    assign bus.wr_err       = wr_err_q;
    assign bus.iter         = iter_q;
    assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_cgra_cfg_sequencer.sv
// Bench for cgra_cfg_sequencer: table of playback scenarios plus hand-written abort,
// write-rejection and reset sequences; frames are checked against a queue of expectations.
module tb_cgra_cfg_sequencer;
    import cgra_cfg_pkg::*;

    localparam int DEPTH = 16;
    localparam int IW    = 8;
    localparam int W     = FRAME_WIDTH + IW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cgra_cfg_if #(.DEPTH(DEPTH), .ITER_WIDTH(IW)) bus ();

    cgra_cfg_sequencer #(.DEPTH(DEPTH), .ITER_WIDTH(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];
    logic [63:0]  mdl [DEPTH];
    int xfer_cnt  = 0;
    int done_cnt  = 0;
    int abort_cnt = 0;
    logic         hold_pend  = 1'b0;
    logic [63:0]  hold_frame = '0;
    logic [W-1:0] mon_e;

    typedef struct {
        int len;
        int loops;
        int stall_lo;
        int stall_n;
        int exp_xfers;
        int exp_cyc;
    } vec_t;
    vec_t vt[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard side: every transfer must match the head of exp_q; stalled frames must hold.
    always @(negedge clk) begin
        if (rst) begin
            hold_pend <= 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", 64'(bus.config_valid), 64'd1);
                check("hold_frame", bus.config_frame, hold_frame);
            end
            if (bus.config_valid && bus.config_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_xfer: got frame %0h expected no transfer", bus.config_frame);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("xfer_frame", bus.config_frame, mon_e[63:0]);
                    check("xfer_iter", 64'(bus.iter), 64'(mon_e[W-1:64]));
                end
                xfer_cnt <= xfer_cnt + 1;
            end
            hold_pend  <= bus.config_valid && !bus.config_ready;
            hold_frame <= bus.config_frame;
            if (bus.done)    done_cnt  <= done_cnt + 1;
            if (bus.aborted) abort_cnt <= abort_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_en        = 1'b0;
        bus.wr_addr      = '0;
        bus.wr_data      = '0;
        bus.start        = 1'b0;
        bus.len          = '0;
        bus.loop_count   = '0;
        bus.abort        = 1'b0;
        bus.config_ready = 1'b1;
    endtask

    task automatic write_frame(input int addr, input logic [63:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'(addr);
        bus.wr_data = data;
        tick();
        bus.wr_en   = 1'b0;
        mdl[addr]   = data;
    endtask

    task automatic push_play(input int len, input int loops);
        int passes;
        passes = (loops == 0) ? 1 : loops;
        for (int ps = 0; ps < passes; ps++)
            for (int p = 0; p < len; p++)
                exp_q.push_back({IW'(ps), mdl[p]});
    endtask

    task automatic start_play(input int len, input int loops);
        bus.start      = 1'b1;
        bus.len        = 5'(len);
        bus.loop_count = IW'(loops);
        tick();
        bus.start      = 1'b0;
    endtask

    task automatic run_to_end(input int lo, input int n, output int cyc);
        cyc = 0;
        while (!(bus.done || bus.aborted) && cyc < 300) begin
            bus.config_ready = !(cyc >= lo && cyc < lo + n);
            tick();
            cyc++;
        end
        bus.config_ready = 1'b1;
        if (cyc >= 300) begin
            n_vec++;
            n_err++;
            $display("FAIL run_timeout: got no done/aborted within %0d cycles, required a pulse", cyc);
        end
    endtask

    initial begin
        int cyc, d0, a0, x0;

        vt[0] = '{len: 3,  loops: 1, stall_lo: 0, stall_n: 0, exp_xfers: 3,  exp_cyc: 3};
        vt[1] = '{len: 2,  loops: 3, stall_lo: 0, stall_n: 0, exp_xfers: 6,  exp_cyc: 6};
        vt[2] = '{len: 3,  loops: 1, stall_lo: 1, stall_n: 4, exp_xfers: 3,  exp_cyc: 7};
        vt[3] = '{len: 4,  loops: 0, stall_lo: 0, stall_n: 0, exp_xfers: 4,  exp_cyc: 4};
        vt[4] = '{len: 16, loops: 2, stall_lo: 5, stall_n: 2, exp_xfers: 32, exp_cyc: 34};
        vt[5] = '{len: 0,  loops: 5, stall_lo: 0, stall_n: 0, exp_xfers: 0,  exp_cyc: 0};
        vt[6] = '{len: 1,  loops: 3, stall_lo: 1, stall_n: 1, exp_xfers: 3,  exp_cyc: 4};

        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid",   64'(bus.config_valid), 64'd0);
        check("rst_frame",   bus.config_frame, 64'd0);
        check("rst_busy",    64'(bus.busy), 64'd0);
        check("rst_done",    64'(bus.done), 64'd0);
        check("rst_aborted", 64'(bus.aborted), 64'd0);
        check("rst_wr_err",  64'(bus.wr_err), 64'd0);
        check("rst_iter",    64'(bus.iter), 64'd0);
        check("rst_state",   64'(bus.dbg_state), 64'(ST_IDLE));

        write_frame(0, 64'(make_frame(OP_ADD, SRC_N, SRC_IMM, 4'd2, 16'd3)));
        write_frame(1, 64'(make_frame(OP_SUB, SRC_N, SRC_IMM, 4'd3, 16'd5)));
        write_frame(2, 64'(make_frame(OP_MAC, SRC_IMM, SRC_N, 4'd1, 16'd2)));
        for (int a = 3; a < DEPTH; a++)
            write_frame(a, {$urandom(), $urandom()});

        for (int i = 0; i < 7; i++) begin
            d0 = done_cnt;
            a0 = abort_cnt;
            x0 = xfer_cnt;
            push_play(vt[i].len, vt[i].loops);
            start_play(vt[i].len, vt[i].loops);
            run_to_end(vt[i].stall_lo, vt[i].stall_n, cyc);
            check($sformatf("v%0d_cycles", i), 64'(cyc), 64'(vt[i].exp_cyc));
            check($sformatf("v%0d_fin_valid", i), 64'(bus.config_valid), 64'd0);
            tick();
            check($sformatf("v%0d_xfers", i), 64'(xfer_cnt - x0), 64'(vt[i].exp_xfers));
            check($sformatf("v%0d_done_cnt", i), 64'(done_cnt - d0), 64'd1);
            check($sformatf("v%0d_abort_cnt", i), 64'(abort_cnt - a0), 64'd0);
            check($sformatf("v%0d_left", i), 64'(exp_q.size()), 64'd0);
            check($sformatf("v%0d_idle", i), 64'(bus.dbg_state), 64'(ST_IDLE));
            exp_q.delete();
        end

        // Abort on the second run cycle, coincident with the transfer of frame 1.
        d0 = done_cnt;
        a0 = abort_cnt;
        exp_q.push_back({IW'(0), mdl[0]});
        exp_q.push_back({IW'(0), mdl[1]});
        start_play(8, 1);
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_valid", 64'(bus.config_valid), 64'd0);
        check("abort_pulse", 64'(bus.aborted), 64'd1);
        check("abort_done",  64'(bus.done), 64'd0);
        check("abort_state", 64'(bus.dbg_state), 64'(ST_FIN));
        tick();
        check("abort_idle",  64'(bus.dbg_state), 64'(ST_IDLE));
        check("abort_cnt",   64'(abort_cnt - a0), 64'd1);
        check("abort_nodone", 64'(done_cnt - d0), 64'd0);
        check("abort_left",  64'(exp_q.size()), 64'd0);
        exp_q.delete();

        // Abort while idle does nothing.
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_idle_pulse", 64'(bus.aborted), 64'd0);

        // Host write during RUN is rejected and frame 1 replays unchanged.
        push_play(3, 1);
        bus.config_ready = 1'b0;
        start_play(3, 1);
        bus.config_ready = 1'b0;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'd1;
        bus.wr_data = 64'hDEAD_BEEF_0BAD_F00D;
        tick();
        bus.wr_en = 1'b0;
        check("wr_err_pulse", 64'(bus.wr_err), 64'd1);
        tick();
        check("wr_err_clear", 64'(bus.wr_err), 64'd0);
        run_to_end(0, 0, cyc);
        tick();
        check("wr_run_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();

        // start coincident with a write in IDLE: write lands, no playback.
        x0 = xfer_cnt;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'd2;
        bus.wr_data = {$urandom(), $urandom()};
        bus.start   = 1'b1;
        bus.len     = 5'd3;
        bus.loop_count = 8'd1;
        mdl[2] = bus.wr_data;
        tick();
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        check("startwr_valid", 64'(bus.config_valid), 64'd0);
        check("startwr_state", 64'(bus.dbg_state), 64'(ST_IDLE));
        tick();
        check("startwr_busy", 64'(bus.busy), 64'd0);
        check("startwr_xfers", 64'(xfer_cnt - x0), 64'd0);
        push_play(3, 1);
        start_play(3, 1);
        run_to_end(0, 0, cyc);
        tick();
        check("startwr_replay_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();

        // Reset in the middle of a stalled run, then a zero-length start.
        d0 = done_cnt;
        a0 = abort_cnt;
        bus.config_ready = 1'b0;
        start_play(8, 2);
        bus.config_ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.config_ready = 1'b1;
        check("mrst_valid",   64'(bus.config_valid), 64'd0);
        check("mrst_frame",   bus.config_frame, 64'd0);
        check("mrst_busy",    64'(bus.busy), 64'd0);
        check("mrst_done",    64'(bus.done), 64'd0);
        check("mrst_aborted", 64'(bus.aborted), 64'd0);
        check("mrst_iter",    64'(bus.iter), 64'd0);
        check("mrst_state",   64'(bus.dbg_state), 64'(ST_IDLE));
        tick();
        check("mrst_no_pulse", 64'(done_cnt - d0 + abort_cnt - a0), 64'd0);
        x0 = xfer_cnt;
        start_play(0, 1);
        check("len0_done",  64'(bus.done), 64'd1);
        check("len0_valid", 64'(bus.config_valid), 64'd0);
        tick();
        check("len0_xfers", 64'(xfer_cnt - x0), 64'd0);
        check("len0_idle",  64'(bus.dbg_state), 64'(ST_IDLE));

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
